serial_add_seq: RTL
===================

Name: serial_add_seq

Overview:
- Bit-serial add sequencer: streams two WIDTH-bit operands LSB-first through a single full-adder cell built from two half-adder cells, one bit per clock.
- A carry flop and a shift-register result form the rest of the datapath.
- Valid/ready on both sides, so it sits between the TT pin-mux logic (ui_in/uio_in operand capture) and the uo_out result drivers.
- Trades latency for area versus a parallel adder.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 1..32).

Ports:
- clk  input  1  clock; all flops on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  block can accept operands; high only in IDLE.
- op_a  input  WIDTH  addend A, sampled on accept.
- op_b  input  WIDTH  addend B, sampled on accept.
- op_sub  input  1  subtract request, sampled on accept. Ignored unless SERIAL_SUB_EN is defined.
- res_valid  output  1  result available; held until taken.
- res_ready  input  1  consumer takes result.
- res_sum  output  WIDTH  sum (or difference).
- res_cout  output  1  carry out (not-borrow when subtracting).
- busy  output  1  high in RUN or DONE.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (async, any state): state=IDLE, bit counter=0, carry=0, A/B/sum shift regs=0.
  - Outputs under and after reset: in_ready=1, res_valid=0, res_sum=0, res_cout=0, busy=0.
- IDLE:
  - in_ready=1.
  - Accept = in_valid & in_ready: load A<=op_a, B<=op_b, carry<=0, counter<=0, go RUN.
  - in_valid low: stay IDLE.
- RUN, one bit per cycle:
  - s = A[0]^B[0]^carry, computed by two half_adder_cell instances plus an OR of their carries.
  - carry <= cout of that bit.
  - A, B shift right.
  - s enters the sum shift register at the MSB, shifting right.
  - counter++.
  - After the cycle where counter == WIDTH-1, go DONE.
  - in_ready=0; in_valid is ignored and not queued.
- DONE:
  - res_valid=1; res_sum = sum reg; res_cout = carry.
  - Both are stable while res_ready=0, for any number of cycles.
  - res_valid & res_ready: go IDLE. res_valid drops next cycle, in_ready rises next cycle.
  - No same-cycle accept of new operands in DONE.
- Latency: accept at edge N; res_valid high from edge N+WIDTH+1. Throughput is one op per WIDTH+2 cycles with res_ready tied high.
- Arithmetic:
  - Result is the modulo 2^WIDTH sum; res_cout is the true carry out of the MSB.
  - Counter width = clog2(WIDTH), minimum 1 bit.
- WIDTH=1: RUN lasts exactly one cycle.
- res_sum keeps its last value after leaving DONE until the next op overwrites it.
- Reset mid-RUN or mid-DONE: the op is discarded, no res_valid pulse; next accept works normally.
- busy = (state != IDLE).

Optional Feature:
- Macro SERIAL_SUB_EN.
- Defined:
  - On accept with op_sub=1: B is loaded as ~op_b and the carry flop is preset to 1.
  - Result is A-B mod 2^WIDTH; res_cout=1 means no borrow.
  - op_sub=0 behaves as add.
- Undefined: op_sub port still present but ignored; carry always initialised to 0; no inverter logic.

Decomposition:
- Package serial_add_pkg:
  - state enum type seq_state_t {IDLE, RUN, DONE}.
  - Localparams for the state encoding.
  - Function cnt_w(width) returning the counter width.
- Sub-module half_adder_cell: 1-bit combinational, inputs a and b, outputs s=a^b and c=a&b.
- serial_add_seq instantiates half_adder_cell twice to form the full-adder bit slice.
- No other sub-modules.

Test Plan:
- WIDTH=8, A=8'hFF, B=8'h01, res_ready=1: accept at cycle 0 -> res_valid at cycle 9, res_sum=8'h00, res_cout=1, in_ready back high at cycle 10.
- A=8'h5A, B=8'h25: res_sum=8'h7F, res_cout=0. Hold res_ready=0 for 5 cycles: res_valid and data stay constant, busy=1, in_ready=0.
- in_valid pulsed with A=8'h11 during RUN of an 8'h03+8'h04 op: first result is 8'h07. The 8'h11 op is not performed and in_ready stays 0 until DONE is consumed.
- rst asserted at cycle 4 of RUN, then accept 8'h80+8'h80: no spurious res_valid; outputs go to reset values; then res_sum=8'h00, res_cout=1.
- WIDTH=1 build, sweep all 4 input pairs: res_valid 2 cycles after accept; 1+1 gives sum=0, cout=1.
- SERIAL_SUB_EN defined:
  - 8'h10-8'h01: 8'h0F, cout=1.
  - 8'h00-8'h01: 8'hFF, cout=0.
  - Macro undefined with op_sub=1, 8'h10,8'h01: result 8'h11 (add).

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial add sequencer.
// State encoding constants, FSM state type and counter sizing.
package serial_add_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ENC_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ENC_RUN  = 2'd1;
    localparam logic [STATE_W-1:0] ENC_DONE = 2'd2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = ENC_IDLE,
        RUN  = ENC_RUN,
        DONE = ENC_DONE
    } seq_state_t;

    // Bit counter width: clog2(width), never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/half_adder_cell.sv
// One-bit half adder; two of these plus an OR form the serial full-adder slice.
module half_adder_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial adder: WIDTH-bit operands are summed LSB-first, one bit per clock.
// Optional macro SERIAL_SUB_EN adds subtraction (A + ~B + 1) selected by op_sub.
module serial_add_seq
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_sub,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             busy
);

    localparam int unsigned CW = cnt_w(WIDTH);

    seq_state_t       state_q;
    seq_state_t       state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;

    logic             accept_c;
    logic             take_c;
    logic             last_bit_c;
    logic [WIDTH-1:0] b_load_c;
    logic             carry_load_c;
    logic [WIDTH-1:0] sum_next_c;

    logic ha0_s;
    logic ha0_c;
    logic ha1_s;
    logic ha1_c;
    logic bit_s;
    logic bit_c;

    // Full-adder slice on the current LSBs and the running carry.
    half_adder_cell u_ha0 (
        .a (a_q[0]),
        .b (b_q[0]),
        .s (ha0_s),
        .c (ha0_c)
    );

    half_adder_cell u_ha1 (
        .a (ha0_s),
        .b (carry_q),
        .s (ha1_s),
        .c (ha1_c)
    );

    assign bit_s = ha1_s;
    assign bit_c = ha0_c | ha1_c;

`ifdef SERIAL_SUB_EN
    // Two's-complement subtract: invert B and inject a carry of one.
    assign b_load_c     = op_sub ? ~op_b : op_b;
    assign carry_load_c = op_sub;
`else
    logic unused_op_sub;
    assign unused_op_sub = op_sub;
    assign b_load_c      = op_b;
    assign carry_load_c  = 1'b0;
`endif

    assign accept_c   = in_valid & in_ready;
    assign take_c     = res_valid & res_ready;
    assign last_bit_c = (cnt_q == CW'(WIDTH - 1));
    assign sum_next_c = (sum_q >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c)   state_d = RUN;
            RUN:     if (last_bit_c) state_d = DONE;
            DONE:    if (take_c)     state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // State and datapath; operands shift out LSB-first, sum shifts in at the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        a_q     <= op_a;
                        b_q     <= b_load_c;
                        carry_q <= carry_load_c;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= bit_c;
                    sum_q   <= sum_next_c;
                    cnt_q   <= cnt_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Handshake/status flags registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b1;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            in_ready  <= (state_d == IDLE);
            res_valid <= (state_d == DONE);
            busy      <= (state_d != IDLE);
        end
    end

    assign res_sum  = sum_q;
    assign res_cout = carry_q;

endmodule
